bf16_mul_pipe: RTL and testbench

//   Pipelined bfloat16 multiplier; the stage directly upstream of the bfloat16 adder in the

---
 rtl/bf16_pkg.sv | 50 +++++
 rtl/bf16_pipe_slice.sv | 36 +++
 rtl/bf16_mul_pipe.sv | 99 +++++++++
 tb/tb_bf16_mul_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// bfloat16 format constants and shared types for the multiply stage of the
// fused multiply-add datapath.
package bf16_pkg;

    localparam int BF16_W      = 16;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_MAN_W  = 7;
    localparam int BF16_BIAS   = 127;
    localparam int BF16_EXP_MAX = 255;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } bf16_class_t;

    typedef struct packed {
        logic                  sign;
        logic [BF16_EXP_W-1:0] exp;
        logic [BF16_MAN_W-1:0] man;
    } bf16_fields_t;

    // Stage-2 payload: raw significand product and unnormalised exponent
    typedef struct packed {
        logic        sign;
        logic [15:0] mp;
        logic [9:0]  es;
        bf16_class_t ca;
        bf16_class_t cb;
        logic [15:0] c;
    } bf16_s2_t;

    typedef struct packed {
        logic [15:0] prod;
        logic [15:0] addend;
        logic        ovf;
        logic        unf;
    } bf16_s3_t;

    // Subnormals are treated as zero
    function automatic bf16_class_t bf16_classify(input bf16_fields_t f);
        bf16_class_t cl;
        cl.is_zero = (f.exp == 8'h00);
        cl.is_inf  = (f.exp == 8'hFF) && (f.man == 7'h00);
        cl.is_nan  = (f.exp == 8'hFF) && (f.man != 7'h00);
        return cl;
    endfunction

endpackage

// File: rtl/bf16_pipe_slice.sv
// Valid/ready register slice; loads whenever empty or downstream accepts,
// so bubbles collapse and held data stays stable.
module bf16_pipe_slice #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Stage register: capture on load, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/bf16_mul_pipe.sv
// Three-stage bfloat16 multiplier feeding the FMA adder; the addend rides
// alongside the product so the adder sees an aligned {prod, addend} pair.
module bf16_mul_pipe
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic [15:0] addend,
    output logic        ovf,
    output logic        unf
);

    localparam logic [9:0] ES_BIAS = 10'(BF16_BIAS);
    localparam logic [9:0] ES_MAX  = 10'(BF16_EXP_MAX);

    logic         v1_s, v2_s, rdy2_s, rdy3_s;
    logic [47:0]  d1_s;
    bf16_fields_t fa_s, fb_s;
    bf16_s2_t     s2_in_s, s2_q_s;
    bf16_s3_t     s3_in_s, s3_q_s;
    logic [9:0]   es_n_s;
    logic [6:0]   man_s;

    bf16_pipe_slice #(.W(48)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data({a, b, c}),
        .out_valid(v1_s), .out_ready(rdy2_s), .out_data(d1_s)
    );

    assign fa_s = d1_s[47:32];
    assign fb_s = d1_s[31:16];

    // Classify operands, multiply significands, form biased exponent sum
    always_comb begin
        s2_in_s      = '0;
        s2_in_s.sign = fa_s.sign ^ fb_s.sign;
        s2_in_s.mp   = {8'h00, 1'b1, fa_s.man} * {8'h00, 1'b1, fb_s.man};
        s2_in_s.es   = {2'b00, fa_s.exp} + {2'b00, fb_s.exp} - ES_BIAS;
        s2_in_s.ca   = bf16_classify(fa_s);
        s2_in_s.cb   = bf16_classify(fb_s);
        s2_in_s.c    = d1_s[15:0];
    end

    bf16_pipe_slice #(.W($bits(bf16_s2_t))) u_s2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1_s), .in_ready(rdy2_s), .in_data(s2_in_s),
        .out_valid(v2_s), .out_ready(rdy3_s), .out_data(s2_q_s)
    );

    // Normalise (truncating) and resolve special cases in priority order
    always_comb begin
        s3_in_s        = '0;
        s3_in_s.addend = s2_q_s.c;
        if (s2_q_s.mp[15]) begin
            man_s  = s2_q_s.mp[14:8];
            es_n_s = s2_q_s.es + 10'd1;
        end else begin
            man_s  = s2_q_s.mp[13:7];
            es_n_s = s2_q_s.es;
        end
        if (s2_q_s.ca.is_nan || s2_q_s.cb.is_nan ||
            (s2_q_s.ca.is_inf && s2_q_s.cb.is_zero) ||
            (s2_q_s.cb.is_inf && s2_q_s.ca.is_zero)) begin
            s3_in_s.prod = BF16_QNAN;
        end else if (s2_q_s.ca.is_inf || s2_q_s.cb.is_inf) begin
            s3_in_s.prod = {s2_q_s.sign, 8'hFF, 7'h00};
        end else if (s2_q_s.ca.is_zero || s2_q_s.cb.is_zero) begin
            s3_in_s.prod = {s2_q_s.sign, 15'h0000};
        end else if ($signed(es_n_s) >= $signed(ES_MAX)) begin
            s3_in_s.prod = {s2_q_s.sign, 8'hFF, 7'h00};
            s3_in_s.ovf  = 1'b1;
        end else if ($signed(es_n_s) <= $signed(10'd0)) begin
            s3_in_s.prod = {s2_q_s.sign, 15'h0000};
            s3_in_s.unf  = 1'b1;
        end else begin
            s3_in_s.prod = {s2_q_s.sign, es_n_s[7:0], man_s};
        end
    end

    bf16_pipe_slice #(.W($bits(bf16_s3_t))) u_s3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v2_s), .in_ready(rdy3_s), .in_data(s3_in_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(s3_q_s)
    );

    assign prod   = s3_q_s.prod;
    assign addend = s3_q_s.addend;
    assign ovf    = s3_q_s.ovf;
    assign unf    = s3_q_s.unf;

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Scoreboard bench for bf16_mul_pipe: directed cases plus randomized traffic
// with random backpressure, checked against an arithmetic reference model.
module tb_bf16_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = 16'h0000, b = 16'h0000, c = 16'h0000;
    logic        in_ready, out_valid, ovf, unf;
    logic [15:0] prod, addend;

    bf16_mul_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .addend(addend), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        logic [15:0] addend;
        logic        ovf;
        logic        unf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, n_in = 0, n_out = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: value = (1.ma)*(1.mb)*2^(ea+eb-2*bias), truncated to 7 fraction bits
    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] tc);
        exp_t r;
        int ea, eb, m, e;
        bit za, zb, ia, ib, na, nb, s;
        logic [7:0] ef;
        logic [6:0] mf;
        ea = ta[14:7];  eb = tb_[14:7];
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255) && (ta[6:0] == 7'd0);
        ib = (eb == 255) && (tb_[6:0] == 7'd0);
        na = (ea == 255) && !ia;
        nb = (eb == 255) && !ib;
        s  = ta[15] ^ tb_[15];
        r.addend = tc; r.ovf = 1'b0; r.unf = 1'b0; r.acc = 0; r.lat = 1'b0;
        if (na || nb || (ia && zb) || (ib && za)) r.prod = 16'h7FC0;
        else if (ia || ib) r.prod = {s, 15'h7F80};
        else if (za || zb) r.prod = {s, 15'h0000};
        else begin
            m = (128 + int'(ta[6:0])) * (128 + int'(tb_[6:0]));
            e = ea + eb - 127;
            while (m >= 32768) begin
                m = m / 2;
                e = e + 1;
            end
            if (e >= 255) begin
                r.prod = {s, 15'h7F80}; r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.prod = {s, 15'h0000}; r.unf = 1'b1;
            end else begin
                ef = e[7:0];
                mf = m[13:7];
                r.prod = {s, ef, mf};
            end
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one triple; returns at posedge+1 after acceptance
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] tc, input bit lat);
        exp_t e;
        bit done;
        done = 1'b0;
        in_valid = 1'b1; a = ta; b = tb_; c = tc;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(ta, tb_, tc);
                e.acc = cyc;
                e.lat = lat;
                q.push_back(e);
                n_in++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 200 && q.size() != 0; k++) idle(1);
        chk("drain", q.size(), 32'd0);
    endtask

    // Monitor: compare every transferred output against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_output: got prod %h with empty scoreboard", prod);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("prod", prod, e.prod);
                chk("addend", addend, e.addend);
                chk("ovf_unf", {ovf, unf}, {e.ovf, e.unf});
                if (e.lat) chk("latency", cyc - e.acc, 32'd3);
            end
        end
    end

    // Random backpressure during the randomized phase
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t p1;
        logic [15:0] ra, rb;
        idle(2);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_prod", prod, 32'd0);
        chk("rst_addend", addend, 32'd0);
        chk("rst_flags", {ovf, unf}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Unit product, then back-to-back normal products
        send(16'h3F80, 16'h3F80, 16'h4000, 1'b1);
        send(16'h3FC0, 16'h3FC0, 16'h1111, 1'b1);
        send(16'hBF80, 16'h4000, 16'h2222, 1'b1);
        // Exponent overflow / underflow
        send(16'h7F00, 16'h7F00, 16'h3333, 1'b1);
        send(16'h0080, 16'h0080, 16'h4444, 1'b1);
        // Specials
        send(16'h7F80, 16'h0000, 16'h5555, 1'b1);
        send(16'h7FC1, 16'h3F80, 16'h6666, 1'b1);
        send(16'hFF80, 16'h3F80, 16'h7777, 1'b1);
        send(16'h0000, 16'hFF80, 16'h8888, 1'b1);
        send(16'h8000, 16'h4000, 16'h9999, 1'b1);
        send(16'h0040, 16'h4000, 16'hAAAA, 1'b1);
        wait_empty();

        // Stall: three fill the pipe, then in_ready must drop
        out_ready = 1'b0;
        p1 = model(16'h4040, 16'h4000, 16'h0101);
        send(16'h4040, 16'h4000, 16'h0101, 1'b0);
        send(16'h3F00, 16'hC100, 16'h0202, 1'b0);
        send(16'h4120, 16'h3E80, 16'h0303, 1'b0);
        in_valid = 1'b1; a = 16'h4300; b = 16'h4300; c = 16'h0404;
        @(negedge clk);
        chk("stall_in_ready", in_ready, 32'd0);
        chk("stall_out_valid", out_valid, 32'd1);
        chk("stall_prod0", prod, p1.prod);
        @(negedge clk);
        chk("stall_prod1", prod, p1.prod);
        chk("stall_addend", addend, p1.addend);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h4300, 16'h4300, 16'h0404, 1'b0);
        send(16'hC2F0, 16'h3D00, 16'h0505, 1'b0);
        send(16'h5000, 16'h2F00, 16'h0606, 1'b0);
        wait_empty();

        // Reset with items in flight
        out_ready = 1'b0;
        send(16'h4000, 16'h4000, 16'h0A0A, 1'b0);
        send(16'h4080, 16'h4000, 16'h0B0B, 1'b0);
        send(16'h40A0, 16'h4000, 16'h0C0C, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 32'd0);
        chk("reset_prod", prod, 32'd0);
        n_in = n_in - q.size();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(16'h40C0, 16'h3FC0, 16'h0D0D, 1'b1);
        wait_empty();
        idle(4);

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 1) == 0) ra[14:7] = 8'(7'($urandom) + 7'd64);
            if ($urandom_range(0, 1) == 0) rb[14:7] = 8'(7'($urandom) + 7'd64);
            send(ra, rb, 16'($urandom), 1'b0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        idle(1);
        out_ready = 1'b1;
        wait_empty();
        idle(3);
        chk("in_out_count", n_out, n_in);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
